ula_multiciclo: RTL and testbench
=================================

# ula_multiciclo

Parametrised successor to the single-cycle 32-bit ULA: a WIDTH-bit ALU with a start/done handshake, registered outputs, an extended operation set and an iterative multiplier. Single-cycle operations complete in one clock at one per cycle. Multiply operations run for WIDTH cycles and produce a 2·WIDTH-bit product. It sits in the datapath in place of the ULA and is driven by the control unit through the handshake.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; accepted when ocupado=0.
- entrada1  in  WIDTH  operand A, captured on accept.
- entrada2  in  WIDTH  operand B, captured on accept; low SHW bits give the shift amount.
- ALUControl  in  4  operation code, captured on accept.
- ocupado  out  1  high while a multiply is in progress.
- pronto  out  1  one-cycle pulse: result outputs updated.
- resultado  out  WIDTH  result, or the low product word.
- resultado_hi  out  WIDTH  high product word; 0 for non-multiply ops.
- zero  out  1  result equals 0. For multiplies this covers all 2·WIDTH product bits.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- erro  out  1  illegal ALUControl on the last accepted op.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB.
  - 0111 SLT (signed), 0101 SLTU: result is 1 or 0.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift entrada1 by entrada2[SHW-1:0].
  - 1100 MULTU (unsigned), 1101 MULT (signed).
- Any other opcode: resultado=0, resultado_hi=0, zero=1, erro=1, completes as a single-cycle op.
- Arithmetic is modulo 2^WIDTH. overflow for ADD/SUB follows the standard two's-complement sign rule.
- State machine has two states, OCIOSO and MULTIPLICA. ocupado = (state==MULTIPLICA).
- OCIOSO, inicio=1, single-cycle op: register all outputs at this edge and set pronto=1. State stays OCIOSO.
- OCIOSO, inicio=1, MULTU/MULT: capture operands and go to MULTIPLICA. Iteration counter = 0, partial product = 0.
  - MULT works on operand magnitudes and records the sign (A[msb] xor B[msb]).
- MULTIPLICA: one shift-add step per edge. On step WIDTH:
  - form the final product, two's-complement negating it for MULT with differing signs;
  - write resultado_hi:resultado, zero, overflow=0, erro=0, pronto=1;
  - return to OCIOSO.
- inicio while ocupado=1 is ignored; no queuing.
- Outputs hold their values until the next completion.

## Timing
- Reset (async, any state, including mid-multiply):
  - state=OCIOSO, counter=0;
  - resultado=0, resultado_hi=0, zero=0, overflow=0, erro=0, pronto=0, ocupado=0.
  - The in-flight multiply is discarded.
- Single-cycle op accepted at edge k: outputs and pronto=1 are visible after edge k. pronto drops at edge k+1 unless another op is accepted at k+1.
- Throughput: one single-cycle op per clock.
- Multiply accepted at edge k:
  - ocupado=1 after edge k;
  - result and pronto=1 after edge k+WIDTH, with ocupado=0 at the same edge;
  - latency is WIDTH cycles.
- A new start may be accepted in the cycle where pronto=1 after a multiply, because ocupado is already 0.
- Operand, opcode or inicio changes during MULTIPLICA have no effect.
- Result outputs change only on a completion edge or on reset.

## Test plan
- Reset: hold reset_n=0 mid-multiply, then release -> all outputs 0, ocupado=0, no pronto pulse.
- ADD and SUB overflow (WIDTH=32):
  - 1+2 via 0010 -> resultado=3, zero=0, pronto for 1 cycle.
  - 1−1 via 0110 -> resultado=0, zero=1.
  - 0x7FFFFFFF+1 -> resultado=0x80000000, overflow=1.
- Compare and shift (back-to-back starts on consecutive cycles):
  - SLT −1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000; SLL 1 by 31 -> 0x80000000.
  - pronto stays high on every cycle of the sequence.
- Multiply:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, exactly 32 cycles after accept.
  - MULT −3×5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULT 0×−7 -> zero=1.
- Busy rejection: pulse inicio with ADD operands during MULTIPLICA -> ignored; only the multiply result appears.
- Illegal opcode 1111 -> erro=1, resultado=0, zero=1. A following legal op clears erro.
- Repeat the ADD and MULTU cases at WIDTH=8: 0xFF×0xFF -> hi=0xFE, lo=0x01, latency 8 cycles.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: WIDTH-bit ALU with start/done handshake, registered outputs,
// single-cycle logic/arith/compare/shift ops and an iterative shift-add
// multiplier (WIDTH cycles, 2*WIDTH-bit product).
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  input  logic [3:0]       ALUControl,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_hi,
  output logic             zero,
  output logic             overflow,
  output logic             erro
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_SLTU  = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLL   = 4'b1000,
    OP_SRL   = 4'b1001,
    OP_SRA   = 4'b1010,
    OP_MULTU = 4'b1100,
    OP_MULT  = 4'b1101
  } op_t;

  typedef enum logic {
    OCIOSO,
    MULTIPLICA
  } state_t;

  state_t             state;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic               alu_err;
  logic               is_mul;
  logic               is_smul;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;

  assign ocupado = (state == MULTIPLICA);

  // Single-cycle result, flags and multiply operand magnitudes from the live inputs.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    is_smul = 1'b0;
    sum     = entrada1 + entrada2;
    diff    = entrada1 - entrada2;
    shamt   = entrada2[SHW-1:0];
    case (ALUControl)
      OP_AND:  alu_res = entrada1 & entrada2;
      OP_OR:   alu_res = entrada1 | entrada2;
      OP_XOR:  alu_res = entrada1 ^ entrada2;
      OP_NOR:  alu_res = ~(entrada1 | entrada2);
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (entrada1[WIDTH-1] == entrada2[WIDTH-1]) &&
                  (sum[WIDTH-1] != entrada1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (entrada1[WIDTH-1] != entrada2[WIDTH-1]) &&
                  (diff[WIDTH-1] != entrada1[WIDTH-1]);
      end
      OP_SLT:  alu_res = WIDTH'($signed(entrada1) < $signed(entrada2));
      OP_SLTU: alu_res = WIDTH'(entrada1 < entrada2);
      OP_SLL:  alu_res = entrada1 << shamt;
      OP_SRL:  alu_res = entrada1 >> shamt;
      OP_SRA:  alu_res = $signed(entrada1) >>> shamt;
      OP_MULTU: is_mul = 1'b1;
      OP_MULT: begin
        is_mul  = 1'b1;
        is_smul = 1'b1;
      end
      default: alu_err = 1'b1;
    endcase
    mag_a = (is_smul && entrada1[WIDTH-1]) ? -entrada1 : entrada1;
    mag_b = (is_smul && entrada2[WIDTH-1]) ? -entrada2 : entrada2;
  end

  // One shift-add step; the last step's sum is negated for a negative signed product.
  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
    product  = neg ? -acc_step : acc_step;
  end

  // Control FSM with registered result outputs and multiplier datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= OCIOSO;
      count        <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      neg          <= 1'b0;
      pronto       <= 1'b0;
      resultado    <= '0;
      resultado_hi <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      erro         <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (inicio) begin
            if (is_mul) begin
              state  <= MULTIPLICA;
              count  <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, mag_a};
              mplier <= mag_b;
              neg    <= is_smul && (entrada1[WIDTH-1] ^ entrada2[WIDTH-1]);
            end else begin
              resultado    <= alu_res;
              resultado_hi <= '0;
              zero         <= (alu_res == '0);
              overflow     <= alu_ov;
              erro         <= alu_err;
              pronto       <= 1'b1;
            end
          end
        end
        MULTIPLICA: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            resultado    <= product[WIDTH-1:0];
            resultado_hi <= product[2*WIDTH-1:WIDTH];
            zero         <= (product == '0);
            overflow     <= 1'b0;
            erro         <= 1'b0;
            pronto       <= 1'b1;
            state        <= OCIOSO;
          end
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo at WIDTH=32 and WIDTH=8.
module tb_ula_multiciclo;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad = 0;

  // 32-bit instance
  logic        ini32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  op32 = '0;
  logic        ocu32, pr32, z32, ov32, er32;
  logic [31:0] res32, hi32;

  // 8-bit instance
  logic        ini8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  op8 = '0;
  logic        ocu8, pr8, z8, ov8, er8;
  logic [7:0]  res8, hi8;

  ula_multiciclo #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .inicio(ini32),
    .entrada1(a32), .entrada2(b32), .ALUControl(op32),
    .ocupado(ocu32), .pronto(pr32), .resultado(res32), .resultado_hi(hi32),
    .zero(z32), .overflow(ov32), .erro(er32)
  );

  ula_multiciclo #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .inicio(ini8),
    .entrada1(a8), .entrada2(b8), .ALUControl(op8),
    .ocupado(ocu8), .pronto(pr8), .resultado(res8), .resultado_hi(hi8),
    .zero(z8), .overflow(ov8), .erro(er8)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        er;
    int unsigned cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32e, m8e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values held in 64-bit containers.
  function automatic exp_t model(input int unsigned w, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] mask, ua, ub, sa, sb, p;
    longint      s, maxp;
    int unsigned sh;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? (ua | ~mask) : ua;
    sb   = ub[w-1] ? (ub | ~mask) : ub;
    sh   = 32'(ub % 64'(w));
    maxp = longint'((64'd1 << (w - 1)) - 64'd1);
    e    = '{lo: '0, hi: '0, z: 1'b0, ov: 1'b0, er: 1'b0, cyc: 0};
    p    = '0;
    case (op)
      4'd0:  p = ua & ub;
      4'd1:  p = ua | ub;
      4'd2:  begin p = ua + ub; s = $signed(sa) + $signed(sb); e.ov = (s > maxp) || (s < -maxp - 1); end
      4'd3:  p = ua ^ ub;
      4'd4:  p = ~(ua | ub);
      4'd5:  p = (ua < ub) ? 64'd1 : 64'd0;
      4'd6:  begin p = ua - ub; s = $signed(sa) - $signed(sb); e.ov = (s > maxp) || (s < -maxp - 1); end
      4'd7:  p = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      4'd8:  p = ua << sh;
      4'd9:  p = ua >> sh;
      4'd10: p = $signed(sa) >>> sh;
      4'd12: p = ua * ub;
      4'd13: p = sa * sb;
      default: e.er = 1'b1;
    endcase
    e.lo = 32'(p & mask);
    if (op == 4'd12 || op == 4'd13) e.hi = 32'((p >> w) & mask);
    e.z = (e.lo == 32'd0) && (e.hi == 32'd0);
    return e;
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == 4'd12) || (op == 4'd13);
  endfunction

  // Drive one request on dut d (0: 32-bit, 1: 8-bit), waiting out a busy multiplier.
  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned n;
    int unsigned w;
    n = 0;
    w = (d == 0) ? 32 : 8;
    @(negedge clock);
    while (((d == 0) ? ocu32 : ocu8) && n < 200) begin
      if (d == 0) ini32 = 1'b0; else ini8 = 1'b0;
      n++;
      @(negedge clock);
    end
    if (n >= 200) begin
      chk("busy_timeout", 64'(n), 64'd0);
      return;
    end
    if (d == 0) begin
      a32 = a; b32 = b; op32 = op; ini32 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; ini8 = 1'b1;
    end
    e = model(w, op, a, b);
    e.cyc = cyc + 1 + (is_mul(op) ? w : 0);
    if (d == 0) q32.push_back(e); else q8.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    ini32 = 1'b0;
    ini8  = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor for the 32-bit instance.
  always @(negedge clock) begin
    if (reset_n && pr32) begin
      if (q32.size() == 0) begin
        chk("unexpected_pronto32", 64'd1, 64'd0);
      end else begin
        m32e = q32.pop_front();
        chk("cyc32", 64'(cyc), 64'(m32e.cyc));
        chk("lo32", 64'(res32), 64'(m32e.lo));
        chk("hi32", 64'(hi32), 64'(m32e.hi));
        chk("flags32", {61'd0, z32, ov32, er32}, {61'd0, m32e.z, m32e.ov, m32e.er});
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clock) begin
    if (reset_n && pr8) begin
      if (q8.size() == 0) begin
        chk("unexpected_pronto8", 64'd1, 64'd0);
      end else begin
        m8e = q8.pop_front();
        chk("cyc8", 64'(cyc), 64'(m8e.cyc));
        chk("lo8", 64'(res8), 64'(m8e.lo));
        chk("hi8", 64'(hi8), 64'(m8e.hi));
        chk("flags8", {61'd0, z8, ov8, er8}, {61'd0, m8e.z, m8e.ov, m8e.er});
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res32"}, {res32, hi32}, 64'd0);
    chk({tag, "_flags32"}, {59'd0, z32, ov32, er32, pr32, ocu32}, 64'd0);
    chk({tag, "_res8"}, {48'd0, res8, hi8}, 64'd0);
    chk({tag, "_flags8"}, {59'd0, z8, ov8, er8, pr8, ocu8}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset_init");
    reset_n = 1'b1;

    // ADD/SUB and overflow
    issue(0, 4'b0010, 32'd1, 32'd2);
    idle();
    issue(0, 4'b0110, 32'd1, 32'd1);
    issue(0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    issue(0, 4'b0110, 32'h8000_0000, 32'd1);
    idle();
    repeat (2) @(negedge clock);

    // Back-to-back compare and shift
    issue(0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(0, 4'b0101, 32'hFFFF_FFFF, 32'd1);
    issue(0, 4'b1010, 32'h8000_0000, 32'd4);
    issue(0, 4'b1000, 32'd1, 32'd31);
    issue(0, 4'b1001, 32'h8000_0000, 32'd63);
    idle();

    // Multiplies, including a start in the completion cycle
    issue(0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, 4'b1101, 32'hFFFF_FFFD, 32'd5);
    issue(0, 4'b1101, 32'd0, 32'hFFFF_FFF9);
    issue(0, 4'b1101, 32'h8000_0000, 32'h8000_0000);
    issue(0, 4'b0010, 32'd5, 32'd6);

    // Busy rejection: ADD requests while the multiplier runs
    issue(0, 4'b1100, 32'd1234, 32'd5678);
    @(negedge clock);
    chk("busy_ocupado", 64'(ocu32), 64'd1);
    op32 = 4'b0010; a32 = 32'd1; b32 = 32'd2; ini32 = 1'b1;
    repeat (3) @(negedge clock);
    ini32 = 1'b0;

    // Illegal opcode, then a legal op clears erro
    issue(0, 4'b1111, 32'd9, 32'd9);
    issue(0, 4'b1011, 32'd9, 32'd9);
    issue(0, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    idle();

    // WIDTH=8 directed
    issue(1, 4'b0010, 32'd1, 32'd2);
    issue(1, 4'b0010, 32'h7F, 32'd1);
    issue(1, 4'b1100, 32'hFF, 32'hFF);
    issue(1, 4'b1101, 32'hFD, 32'd5);
    issue(1, 4'b1010, 32'h80, 32'd9);
    idle();

    // Randomized traffic on both widths
    for (int i = 0; i < 200; i++) issue(0, 4'($urandom_range(0, 15)), pick(), pick());
    idle();
    for (int i = 0; i < 80; i++) issue(1, 4'($urandom_range(0, 15)), pick(), pick());
    idle();

    // Drain, then reset in the middle of a multiply
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain_before_reset", 64'(q32.size() + q8.size()), 64'd0);

    issue(0, 4'b1101, 32'hFFFF_FFFD, 32'd7);
    idle();
    repeat (5) @(negedge clock);
    chk("mid_mul_ocupado", 64'(ocu32), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_async");
    q32.delete();
    q8.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk_reset_outputs("reset_after");

    // A fresh op after reset still works
    issue(0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    idle();
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_final", 64'(q32.size() + q8.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
